vga_timing_generator: RTL and testbench

Parametrised VGA raster timing generator that replaces the fixed 640-column counter in the display path. Produces horizontal/vertical sync, active-video flag, pixel coordinates, a row-major video-memory read address, and line/frame start strobes for any mode set by parameters. Sits between the pixel-clock enable source and the video-memory read port and colour output stage.

---
 rtl/vga_timing_generator_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 27 ++
 rtl/vga_timing_generator.sv | 106 ++++++++++
 tb/tb_vga_timing_generator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_generator_pkg.sv
// Shared raster mode constants (default 640x480@60) and helpers for the display path.
// Colour, memory and timing blocks import this so they all agree on one mode.
package vga_timing_generator_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Decoded per-slot flags, registered together so they always describe the same pixel.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic line_start;
        logic frame_start;
    } slot_flags_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: modulo-(MAX+1) raster axis counter with an at-max (wrap) flag.
// Latency: count updates on the edge where tick=1; wrap is combinational from count.
// Backpressure: none; tick=0 simply holds the count.
module vga_axis_counter #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned MAX   = 799
) (
    input  logic             core_clk,
    input  logic             arst_n,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);

    assign wrap = (count == MAX_C);

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// Purpose: parametrised VGA raster timing: syncs, active flag, coordinates, row-major vmem address, strobes.
// Latency: one pixel tick; outputs describe the slot decoded from the counters before they advance.
// Backpressure: none; iPixelEn=0 freezes every register, so all levels stretch across idle clocks.
module vga_timing_generator
    import vga_timing_generator_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iPixelEn,
    output logic              oHS,
    output logic              oVS,
    output logic              oActive,
    output logic [CNT_W-1:0]  oCol,
    output logic [CNT_W-1:0]  oRow,
    output logic [ADDR_W-1:0] oVmemAddress,
    output logic              oLineStart,
    output logic              oFrameStart
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Inclusive sync bounds keep every constant below the axis total, so they fit in CNT_W.
    localparam logic [CNT_W-1:0] H_ACT_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  vcnt;
    logic              h_wrap;
    logic              v_wrap;
    logic [ADDR_W-1:0] next_addr;
    slot_flags_t       slot;

    vga_axis_counter #(.CNT_W(CNT_W), .MAX(H_TOTAL - 1)) u_hcnt (
        .core_clk (Clock),
        .arst_n   (Reset),
        .tick     (iPixelEn),
        .count    (hcnt),
        .wrap     (h_wrap)
    );

    vga_axis_counter #(.CNT_W(CNT_W), .MAX(V_TOTAL - 1)) u_vcnt (
        .core_clk (Clock),
        .arst_n   (Reset),
        .tick     (iPixelEn && h_wrap),
        .count    (vcnt),
        .wrap     (v_wrap)
    );

    always_comb begin
        slot             = '0;
        slot.active      = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
        slot.hs          = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
        slot.vs          = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
        slot.line_start  = (hcnt == '0);
        slot.frame_start = (hcnt == '0) && (vcnt == '0);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            next_addr    <= '0;
            oCol         <= '0;
            oRow         <= '0;
            oVmemAddress <= '0;
            oActive      <= 1'b0;
            oLineStart   <= 1'b0;
            oFrameStart  <= 1'b0;
            oHS          <= ~HS_POL;
            oVS          <= ~VS_POL;
        end else if (iPixelEn) begin
            oCol        <= hcnt;
            oRow        <= vcnt;
            oActive     <= slot.active;
            oLineStart  <= slot.line_start;
            oFrameStart <= slot.frame_start;
            oHS         <= slot.hs ? HS_POL : ~HS_POL;
            oVS         <= slot.vs ? VS_POL : ~VS_POL;
            // Running address instead of row*H_ACTIVE+col; (0,0) re-seeds it every frame.
            if (slot.frame_start) begin
                oVmemAddress <= '0;
                next_addr    <= ADDR_W'(1);
            end else if (slot.active) begin
                oVmemAddress <= next_addr;
                next_addr    <= next_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: default 640x480 instance plus a small 8x4 mode instance sharing clock, reset and pixel enable.
module tb_vga_timing_generator;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
        logic [9:0]  col;
        logic [9:0]  row;
        logic [18:0] addr;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic iPixelEn = 1'b0;

    logic        d_hs, d_vs, d_act, d_ls, d_fs;
    logic [9:0]  d_col, d_row;
    logic [18:0] d_addr;
    logic        s_hs, s_vs, s_act, s_ls, s_fs;
    logic [9:0]  s_col, s_row;
    logic [18:0] s_addr;

    always #5 Clock = ~Clock;

    vga_timing_generator dut_def (
        .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn),
        .oHS(d_hs), .oVS(d_vs), .oActive(d_act), .oCol(d_col), .oRow(d_row),
        .oVmemAddress(d_addr), .oLineStart(d_ls), .oFrameStart(d_fs)
    );

    vga_timing_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut_small (
        .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn),
        .oHS(s_hs), .oVS(s_vs), .oActive(s_act), .oCol(s_col), .oRow(s_row),
        .oVmemAddress(s_addr), .oLineStart(s_ls), .oFrameStart(s_fs)
    );

    int n_checks = 0;
    int n_fail   = 0;
    exp_t qd[$];
    exp_t qs[$];
    int dc = 0, dr = 0, sc = 0, sr = 0;

    bit stats_on = 0;
    int n_def_ls = 0, n_def_hs_low = 0, n_small_fs = 0;
    int small_last_addr = -1;

    // Reference raster: expected outputs for slot (c,r) straight from the mode formulas.
    function automatic exp_t model(input bit sm, input int c, input int r);
        exp_t e;
        int ha = sm ? 8 : 640;
        int hf = sm ? 2 : 16;
        int hw = sm ? 2 : 96;
        int va = sm ? 4 : 480;
        int vf = sm ? 1 : 10;
        int vw = sm ? 1 : 2;
        logic hp = sm;
        logic vp = 1'b0;
        e.col  = 10'(c);
        e.row  = 10'(r);
        e.act  = (c < ha) && (r < va);
        e.hs   = (c >= ha + hf && c < ha + hf + hw) ? hp : ~hp;
        e.vs   = (r >= va + vf && r < va + vf + vw) ? vp : ~vp;
        e.ls   = (c == 0);
        e.fs   = (c == 0) && (r == 0);
        if (r >= va)      e.addr = 19'(ha * va - 1);
        else if (c >= ha) e.addr = 19'(r * ha + ha - 1);
        else              e.addr = 19'(r * ha + c);
        return e;
    endfunction

    function automatic exp_t rst_exp(input bit sm);
        exp_t e;
        e      = '0;
        e.hs   = sm ? 1'b0 : 1'b1;
        e.vs   = 1'b1;
        return e;
    endfunction

    task automatic cmp(input string name, input exp_t a, input exp_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s t=%0t: got hs=%b vs=%b act=%b ls=%b fs=%b col=%0d row=%0d addr=%0d, expected hs=%b vs=%b act=%b ls=%b fs=%b col=%0d row=%0d addr=%0d",
                     name, $time, a.hs, a.vs, a.act, a.ls, a.fs, a.col, a.row, a.addr,
                     e.hs, e.vs, e.act, e.ls, e.fs, e.col, e.row, e.addr);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: on every clock edge compare both DUTs against the current expected slot.
    initial begin
        exp_t cur_d, cur_s;
        logic en_s;
        cur_d = rst_exp(0);
        cur_s = rst_exp(1);
        forever begin
            @(posedge Clock);
            en_s = iPixelEn;
            #1;
            if (!Reset) begin
                cur_d = rst_exp(0);
                cur_s = rst_exp(1);
            end else if (en_s) begin
                if (qd.size() == 0 || qs.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_underflow t=%0t: got empty queue, expected a pending slot", $time);
                end else begin
                    cur_d = qd.pop_front();
                    cur_s = qs.pop_front();
                end
                if (stats_on) begin
                    if (d_ls) n_def_ls++;
                    if (d_row == 10'd0 && d_hs == 1'b0) n_def_hs_low++;
                    if (s_fs) n_small_fs++;
                    if (s_col == 10'd7 && s_row == 10'd3) small_last_addr = int'(s_addr);
                end
            end
            cmp("def_slot", {d_hs, d_vs, d_act, d_ls, d_fs, d_col, d_row, d_addr}, cur_d);
            cmp("small_slot", {s_hs, s_vs, s_act, s_ls, s_fs, s_col, s_row, s_addr}, cur_s);
        end
    end

    task automatic drive(input bit en);
        @(negedge Clock);
        iPixelEn = en;
        if (en) begin
            qd.push_back(model(0, dc, dr));
            qs.push_back(model(1, sc, sr));
            dc++;
            if (dc == 800) begin dc = 0; dr = (dr == 524) ? 0 : dr + 1; end
            sc++;
            if (sc == 14) begin sc = 0; sr = (sr == 6) ? 0 : sr + 1; end
        end
    endtask

    initial begin
        repeat (3) @(negedge Clock);
        Reset = 1'b1;

        // Continuous ticks: two full default lines and ~17 small frames.
        stats_on = 1;
        repeat (1700) drive(1);
        @(negedge Clock);
        iPixelEn = 1'b0;
        stats_on = 0;
        check_val("def_linestart_count", n_def_ls, 3);
        check_val("def_hs_low_ticks_row0", n_def_hs_low, 96);
        check_val("small_framestart_count", n_small_fs, 18);
        check_val("small_last_visible_addr", small_last_addr, 31);

        // Half-rate enable: every register must hold across the idle clock.
        for (int i = 0; i < 900; i++) begin
            drive(1);
            drive(0);
        end

        // Asynchronous reset in the middle of a line, away from any clock edge.
        @(negedge Clock);
        iPixelEn = 1'b1;
        #2 Reset = 1'b0;
        #1;
        cmp("def_async_reset", {d_hs, d_vs, d_act, d_ls, d_fs, d_col, d_row, d_addr}, rst_exp(0));
        cmp("small_async_reset", {s_hs, s_vs, s_act, s_ls, s_fs, s_col, s_row, s_addr}, rst_exp(1));
        dc = 0; dr = 0; sc = 0; sr = 0;
        @(negedge Clock);
        Reset = 1'b1;
        iPixelEn = 1'b0;

        repeat (250) drive(1);
        drive(0);
        drive(0);
        check_val("queues_drained", qd.size() + qs.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
